// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared mode and direction encodings for the speed ramp sequencer
package speed_pkg;

    typedef enum logic [1:0] {
        MODE_SWEEP = 2'b00,
        MODE_RAMP  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Reserved encoding is treated exactly like HOLD.
    function automatic logic is_frozen(input mode_e m);
        return (m == MODE_HOLD) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/speed_ramp_sequencer_if.sv
// rtl/speed_ramp_sequencer_if.sv - control and status bundle of the speed ramp sequencer
interface speed_ramp_sequencer_if #(
    parameter int SPD_W   = 3,
    parameter int DWELL_W = 8
) ();
    logic               en;
    logic [1:0]         mode;
    logic [SPD_W-1:0]   target;
    logic [DWELL_W-1:0] dwell;
    logic [SPD_W-1:0]   speed_out;
    logic               dir_up;
    logic               at_limit;
    logic               at_target;

    modport master (
        output en, mode, target, dwell,
        input  speed_out, dir_up, at_limit, at_target
    );

    modport slave (
        input  en, mode, target, dwell,
        output speed_out, dir_up, at_limit, at_target
    );
endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - counts enabled cycles 0..dwell and pulses tick on the last one
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    logic [DWELL_W-1:0] count_q, count_d;

    // >= rather than == so a dwell shrunk below the running count ticks at once.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (en) begin
            if (clr) begin
                count_d = '0;
            end else if (count_q >= dwell) begin
                tick    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/speed_ramp_sequencer.sv
// rtl/speed_ramp_sequencer.sv - sweeps or ramps a speed code one step per dwell interval
module speed_ramp_sequencer
    import speed_pkg::*;
#(
    parameter int SPD_W   = 3,
    parameter int MIN_LVL = 1,
    parameter int MAX_LVL = 6,
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    speed_ramp_sequencer_if.slave  bus
);

    localparam logic [SPD_W-1:0] MIN_C = SPD_W'(MIN_LVL);
    localparam logic [SPD_W-1:0] MAX_C = SPD_W'(MAX_LVL);
    localparam logic [SPD_W-1:0] ONE   = SPD_W'(1);

    logic [SPD_W-1:0] speed_q, speed_d;
    dir_e             dir_q, dir_d;
    mode_e            prev_mode_q, prev_mode_d;
    mode_e            mode_in;
    logic [SPD_W-1:0] tgt_c;
    logic             mode_chg;
    logic             clr;
    logic             tick;

    assign mode_in  = mode_e'(bus.mode);
    assign mode_chg = (mode_in != prev_mode_q);
    // A mode change restarts the dwell interval and swallows that cycle's step.
    assign clr      = mode_chg || is_frozen(mode_in);

    always_comb begin
        if (bus.target < MIN_C) begin
            tgt_c = MIN_C;
        end else if (bus.target > MAX_C) begin
            tgt_c = MAX_C;
        end else begin
            tgt_c = bus.target;
        end
    end

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .clr   (clr),
        .dwell (bus.dwell),
        .tick  (tick)
    );

    always_comb begin
        speed_d     = speed_q;
        dir_d       = dir_q;
        prev_mode_d = prev_mode_q;
        if (bus.en) begin
            prev_mode_d = mode_in;
        end
        if (tick) begin
            case (mode_in)
                MODE_SWEEP: begin
                    if (dir_q == DIR_UP) begin
                        if (speed_q < MAX_C) begin
                            speed_d = speed_q + ONE;
                        end else begin
                            speed_d = speed_q - ONE;
                            dir_d   = DIR_DOWN;
                        end
                    end else begin
                        if (speed_q > MIN_C) begin
                            speed_d = speed_q - ONE;
                        end else begin
                            speed_d = speed_q + ONE;
                            dir_d   = DIR_UP;
                        end
                    end
                end
                MODE_RAMP: begin
                    if (speed_q < tgt_c) begin
                        speed_d = speed_q + ONE;
                        dir_d   = DIR_UP;
                    end else if (speed_q > tgt_c) begin
                        speed_d = speed_q - ONE;
                        dir_d   = DIR_DOWN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_q     <= MIN_C;
            dir_q       <= DIR_UP;
            prev_mode_q <= MODE_HOLD;
        end else begin
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            prev_mode_q <= prev_mode_d;
        end
    end

    assign bus.speed_out = speed_q;
    assign bus.dir_up    = (dir_q == DIR_UP);
    assign bus.at_limit  = (speed_q == MIN_C) || (speed_q == MAX_C);
    assign bus.at_target = (mode_in == MODE_RAMP) && (speed_q == tgt_c);

endmodule

// File: tb/tb_speed_ramp_sequencer.sv
// tb/tb_speed_ramp_sequencer.sv - self-checking bench for speed_ramp_sequencer
module tb_speed_ramp_sequencer;

    localparam int MINL = 1;
    localparam int MAXL = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    speed_ramp_sequencer_if #(.SPD_W(3), .DWELL_W(8)) bus ();

    speed_ramp_sequencer #(
        .SPD_W   (3),
        .MIN_LVL (MINL),
        .MAX_LVL (MAXL),
        .DWELL_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_spd;
    int m_prev;
    int m_cnt;
    bit m_dir;

    function automatic int clampt(int t);
        if (t < MINL) return MINL;
        if (t > MAXL) return MAXL;
        return t;
    endfunction

    task automatic model_reset();
        m_spd  = MINL;
        m_dir  = 1'b1;
        m_cnt  = 0;
        m_prev = 2;
    endtask

    // Reference: one enabled cycle either restarts the interval (mode change / hold),
    // advances it, or completes it and moves the speed one code by the mode's rule.
    task automatic model_edge();
        int md, tg;
        md = int'(bus.mode);
        if (bus.en !== 1'b1) return;
        if (md != m_prev || md >= 2) begin
            m_cnt = 0;
        end else if (m_cnt >= int'(bus.dwell)) begin
            m_cnt = 0;
            if (md == 0) begin
                if (m_dir && m_spd == MAXL) m_dir = 1'b0;
                else if (!m_dir && m_spd == MINL) m_dir = 1'b1;
                m_spd = m_spd + (m_dir ? 1 : -1);
            end else begin
                tg = clampt(int'(bus.target));
                if (tg != m_spd) begin
                    m_dir = (tg > m_spd);
                    m_spd = m_spd + (m_dir ? 1 : -1);
                end
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_prev = md;
    endtask

    function automatic logic [5:0] exp_vec();
        logic lim, tgt;
        lim = (m_spd == MINL) || (m_spd == MAXL);
        tgt = (bus.mode == 2'b01) && (m_spd == clampt(int'(bus.target)));
        return {3'(m_spd), m_dir, lim, tgt};
    endfunction

    task automatic tick_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.en     = 1'b0;
        bus.mode   = 2'b10;
        bus.target = 3'd0;
        bus.dwell  = 8'd0;
        rst        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== 6'b001_1_1_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b",
                     {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, 6'b001_1_1_0);
        end
        bus.mode = 2'b01;
        #1;
        n_checks++;
        if (bus.at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_at_target_clamped: got %b expected 1", bus.at_target);
        end
        bus.mode = 2'b10;
        rst      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep_dwell0();
        int seq [12];
        seq = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2};
        do_reset();
        bus.mode  = 2'b00;
        bus.dwell = 8'd0;
        bus.en    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick_clk();
            n_checks++;
            if (bus.speed_out !== 3'(seq[i])) begin
                n_fail++;
                $display("FAIL sweep0_seq[%0d]: got %0d expected %0d", i, bus.speed_out, seq[i]);
            end
            n_checks++;
            if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== exp_vec()) begin
                n_fail++;
                $display("FAIL sweep0_model[%0d]: got %b expected %b", i,
                         {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, exp_vec());
            end
        end
    endtask

    task automatic test_sweep_dwell3();
        logic [2:0] prev_spd, frozen;
        int run, changes;
        do_reset();
        bus.mode  = 2'b00;
        bus.dwell = 8'd3;
        bus.en    = 1'b1;
        prev_spd  = 3'd1;
        run       = 0;
        changes   = 0;
        for (int i = 0; i < 30; i++) begin
            tick_clk();
            if (bus.speed_out !== prev_spd) begin
                if (changes > 0) begin
                    n_checks++;
                    if (run != 4) begin
                        n_fail++;
                        $display("FAIL sweep3_hold_len: got %0d cycles expected 4", run);
                    end
                end
                changes++;
                run      = 1;
                prev_spd = bus.speed_out;
            end else begin
                run++;
            end
            n_checks++;
            if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== exp_vec()) begin
                n_fail++;
                $display("FAIL sweep3_model[%0d]: got %b expected %b", i,
                         {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, exp_vec());
            end
        end
        tick_clk();
        bus.en = 1'b0;
        frozen = bus.speed_out;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            n_checks++;
            if (bus.speed_out !== frozen) begin
                n_fail++;
                $display("FAIL sweep3_en_low_frozen: got %0d expected %0d", bus.speed_out, frozen);
            end
        end
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick_clk();
            n_checks++;
            if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== exp_vec()) begin
                n_fail++;
                $display("FAIL sweep3_resume[%0d]: got %b expected %b", i,
                         {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, exp_vec());
            end
        end
    endtask

    task automatic test_ramp();
        int seq [10];
        seq = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        do_reset();
        bus.mode   = 2'b01;
        bus.target = 3'd5;
        bus.dwell  = 8'd1;
        bus.en     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            n_checks++;
            if (bus.speed_out !== 3'(seq[i])) begin
                n_fail++;
                $display("FAIL ramp_seq[%0d]: got %0d expected %0d", i, bus.speed_out, seq[i]);
            end
        end
        n_checks++;
        if (bus.at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_at_target_5: got %b expected 1", bus.at_target);
        end
        bus.target = 3'd7;
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            n_checks++;
            if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== exp_vec()) begin
                n_fail++;
                $display("FAIL ramp_clamp_model[%0d]: got %b expected %b", i,
                         {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, exp_vec());
            end
        end
        n_checks++;
        if ({bus.speed_out, bus.at_target} !== {3'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL ramp_clamp_stop: got %0d/%b expected 6/1", bus.speed_out, bus.at_target);
        end
    endtask

    task automatic test_hold_then_sweep();
        int waited;
        do_reset();
        bus.mode   = 2'b01;
        bus.target = 3'd4;
        bus.dwell  = 8'd2;
        bus.en     = 1'b1;
        waited     = 0;
        while (m_spd != 4 && waited < 40) begin
            tick_clk();
            waited++;
        end
        n_checks++;
        if (bus.speed_out !== 3'd4) begin
            n_fail++;
            $display("FAIL hold_ramp_reach4: got %0d expected 4", bus.speed_out);
        end
        bus.mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            n_checks++;
            if ({bus.speed_out, bus.dir_up} !== {3'd4, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_frozen[%0d]: got %0d/%b expected 4/1", i, bus.speed_out, bus.dir_up);
            end
        end
        bus.mode = 2'b00;
        waited   = 0;
        while (bus.speed_out === 3'd4 && waited < 30) begin
            tick_clk();
            waited++;
        end
        // One mode-change cycle, then dwell+1 enabled cycles.
        n_checks++;
        if (waited != 1 + 3) begin
            n_fail++;
            $display("FAIL hold_sweep_first_step: got %0d cycles expected %0d", waited, 4);
        end
        n_checks++;
        if ({bus.speed_out, bus.dir_up} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_sweep_dir_kept: got %0d/%b expected 5/1", bus.speed_out, bus.dir_up);
        end
    endtask

    task automatic test_reset_mid_dwell();
        int waited;
        do_reset();
        bus.mode  = 2'b00;
        bus.dwell = 8'd5;
        bus.en    = 1'b1;
        waited    = 0;
        while (!(m_spd >= 3 && m_cnt == 2) && waited < 100) begin
            tick_clk();
            waited++;
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.speed_out, bus.dir_up} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_dwell_async: got %0d/%b expected 1/1", bus.speed_out, bus.dir_up);
        end
        #1;
        rst    = 1'b1;
        waited = 0;
        while (bus.speed_out === 3'd1 && waited < 30) begin
            tick_clk();
            waited++;
        end
        n_checks++;
        if (waited != 1 + 6) begin
            n_fail++;
            $display("FAIL rst_mid_dwell_restart: got %0d cycles expected %0d", waited, 7);
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.mode   = 2'b00;
        bus.target = 3'd3;
        bus.dwell  = 8'd1;
        bus.en     = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.mode   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  bus.target = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) bus.dwell  = 8'($urandom_range(0, 4));
            bus.en = ($urandom_range(0, 9) != 0);
            tick_clk();
            n_checks++;
            if ({bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model[%0d]: got %b expected %b", i,
                         {bus.speed_out, bus.dir_up, bus.at_limit, bus.at_target}, exp_vec());
            end
            n_checks++;
            if (bus.speed_out < 3'(MINL) || bus.speed_out > 3'(MAXL)) begin
                n_fail++;
                $display("FAIL random_range[%0d]: got %0d expected %0d..%0d", i, bus.speed_out, MINL, MAXL);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep_dwell0();
        test_sweep_dwell3();
        test_ramp();
        test_hold_then_sweep();
        test_reset_mid_dwell();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
